wakeup_delay_pipe: RTL and testbench

- Parametrised successor to the zero-latency wakeup pass-through.
- Delays an issue-time wakeup (pdest, rfWen/fpWen, robIdx) by exactly LATENCY cycles, so the wakeup reaches the reservation stations when a multi-cycle FU's result becomes available.
- Each in-flight entry is squashed by a redirect, using robIdx age comparison.
- Sits between the issue select logic and the RS wakeup ports in ExuBlock.

---
 rtl/wakeup_delay_pipe.sv | 136 +++++++++++++
 tb/tb_wakeup_delay_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wakeup_delay_pipe.sv
// Delays an issue-time wakeup by LATENCY cycles, squashing in-flight entries on redirect.
// Optional perf counters are enabled by defining WAKEUP_DELAY_PERF_EN.
module wakeup_delay_pipe #(
  parameter int LATENCY = 2,
  parameter int PDEST_W = 6,
  parameter int ROB_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  input  logic               io_in_bits_ctrl_rfWen,
  input  logic               io_in_bits_ctrl_fpWen,
  input  logic [PDEST_W-1:0] io_in_bits_pdest,
  input  logic               io_in_bits_robIdx_flag,
  input  logic [ROB_W-1:0]   io_in_bits_robIdx_value,
  input  logic               io_redirect_valid,
  input  logic               io_redirect_bits_robIdx_flag,
  input  logic [ROB_W-1:0]   io_redirect_bits_robIdx_value,
  input  logic               io_redirect_bits_level,
  output logic               io_out_valid,
  output logic               io_out_bits_ctrl_rfWen,
  output logic               io_out_bits_ctrl_fpWen,
  output logic [PDEST_W-1:0] io_out_bits_pdest,
  output logic               io_out_bits_robIdx_flag,
  output logic [ROB_W-1:0]   io_out_bits_robIdx_value
`ifdef WAKEUP_DELAY_PERF_EN
  ,
  output logic [15:0]        io_perf_flushCnt,
  output logic [15:0]        io_perf_wakeupCnt
`endif
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] rfwen_q, fpwen_q, flag_q;
  logic [PDEST_W-1:0] pdest_q [LATENCY];
  logic [ROB_W-1:0]   value_q [LATENCY];

  logic [LATENCY-1:0] stg_flush;
  logic               in_flush;

  // Age compare with ROB wrap: differing flags invert the value ordering.
  function automatic logic need_flush(input logic e_flag, input logic [ROB_W-1:0] e_value,
                                      input logic r_valid, input logic r_flag,
                                      input logic [ROB_W-1:0] r_value, input logic r_level);
    logic is_after;
    logic is_equal;
    is_after = (e_flag ^ r_flag) ^ (e_value > r_value);
    is_equal = (e_flag == r_flag) && (e_value == r_value);
    return r_valid && (is_after || (is_equal && r_level));
  endfunction

  always_comb begin
    in_flush = need_flush(io_in_bits_robIdx_flag, io_in_bits_robIdx_value,
                          io_redirect_valid, io_redirect_bits_robIdx_flag,
                          io_redirect_bits_robIdx_value, io_redirect_bits_level);
    for (int i = 0; i < LATENCY; i++) begin
      stg_flush[i] = need_flush(flag_q[i], value_q[i],
                                io_redirect_valid, io_redirect_bits_robIdx_flag,
                                io_redirect_bits_robIdx_value, io_redirect_bits_level);
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = io_in_valid & ~in_flush;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1] & ~stg_flush[i-1];
    end
  end

  // Payload shifts every cycle; stage 0 only captures on a valid request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q   <= '0;
      rfwen_q <= '0;
      fpwen_q <= '0;
      flag_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pdest_q[i] <= '0;
        value_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      if (io_in_valid) begin
        rfwen_q[0] <= io_in_bits_ctrl_rfWen;
        fpwen_q[0] <= io_in_bits_ctrl_fpWen;
        flag_q[0]  <= io_in_bits_robIdx_flag;
        pdest_q[0] <= io_in_bits_pdest;
        value_q[0] <= io_in_bits_robIdx_value;
      end
      for (int i = 1; i < LATENCY; i++) begin
        rfwen_q[i] <= rfwen_q[i-1];
        fpwen_q[i] <= fpwen_q[i-1];
        flag_q[i]  <= flag_q[i-1];
        pdest_q[i] <= pdest_q[i-1];
        value_q[i] <= value_q[i-1];
      end
    end
  end

  // A redirect landing in the output cycle still suppresses the wakeup.
  assign io_out_valid             = vld_q[LATENCY-1] & ~stg_flush[LATENCY-1];
  assign io_out_bits_ctrl_rfWen   = rfwen_q[LATENCY-1];
  assign io_out_bits_ctrl_fpWen   = fpwen_q[LATENCY-1];
  assign io_out_bits_pdest        = pdest_q[LATENCY-1];
  assign io_out_bits_robIdx_flag  = flag_q[LATENCY-1];
  assign io_out_bits_robIdx_value = value_q[LATENCY-1];

`ifdef WAKEUP_DELAY_PERF_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] wakeup_cnt_q, wakeup_cnt_d;
  logic        flush_evt;

  always_comb begin
    flush_evt    = (io_in_valid & in_flush) | (|(vld_q & stg_flush));
    flush_cnt_d  = flush_cnt_q;
    wakeup_cnt_d = wakeup_cnt_q;
    if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    if (io_out_valid && (wakeup_cnt_q != 16'hFFFF)) wakeup_cnt_d = wakeup_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_cnt_q  <= '0;
      wakeup_cnt_q <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      wakeup_cnt_q <= wakeup_cnt_d;
    end
  end

  assign io_perf_flushCnt  = flush_cnt_q;
  assign io_perf_wakeupCnt = wakeup_cnt_q;
`endif

endmodule

// File: tb/tb_wakeup_delay_pipe.sv
// Directed-vector bench for wakeup_delay_pipe at LATENCY=2.
module tb_wakeup_delay_pipe;
  localparam int PDEST_W = 6;
  localparam int ROB_W   = 5;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid, in_rf, in_fp, in_flag;
  logic [PDEST_W-1:0] in_pdest;
  logic [ROB_W-1:0]   in_value;
  logic               rd_valid, rd_flag, rd_level;
  logic [ROB_W-1:0]   rd_value;
  logic               out_valid, out_rf, out_fp, out_flag;
  logic [PDEST_W-1:0] out_pdest;
  logic [ROB_W-1:0]   out_value;
`ifdef WAKEUP_DELAY_PERF_EN
  logic [15:0]        perf_flush, perf_wakeup;
`endif

  int n_vec = 0;
  int n_err = 0;

  wakeup_delay_pipe #(.LATENCY(2), .PDEST_W(PDEST_W), .ROB_W(ROB_W)) dut (
    .clock                         (clock),
    .reset                         (reset),
    .io_in_valid                   (in_valid),
    .io_in_bits_ctrl_rfWen         (in_rf),
    .io_in_bits_ctrl_fpWen         (in_fp),
    .io_in_bits_pdest              (in_pdest),
    .io_in_bits_robIdx_flag        (in_flag),
    .io_in_bits_robIdx_value       (in_value),
    .io_redirect_valid             (rd_valid),
    .io_redirect_bits_robIdx_flag  (rd_flag),
    .io_redirect_bits_robIdx_value (rd_value),
    .io_redirect_bits_level        (rd_level),
    .io_out_valid                  (out_valid),
    .io_out_bits_ctrl_rfWen        (out_rf),
    .io_out_bits_ctrl_fpWen        (out_fp),
    .io_out_bits_pdest             (out_pdest),
    .io_out_bits_robIdx_flag       (out_flag),
    .io_out_bits_robIdx_value      (out_value)
`ifdef WAKEUP_DELAY_PERF_EN
    ,
    .io_perf_flushCnt              (perf_flush),
    .io_perf_wakeupCnt             (perf_wakeup)
`endif
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic v, input logic rf, input logic fp,
                        input logic [PDEST_W-1:0] pd, input logic f, input logic [ROB_W-1:0] val);
    in_valid = v; in_rf = rf; in_fp = fp; in_pdest = pd; in_flag = f; in_value = val;
  endtask

  task automatic set_rd(input logic v, input logic f, input logic [ROB_W-1:0] val, input logic lvl);
    rd_valid = v; rd_flag = f; rd_value = val; rd_level = lvl;
  endtask

  task automatic test_reset();
    n_vec++;
    if (out_valid !== 1'b0 || out_pdest !== '0 || out_value !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b pdest=%0h value=%0h, required 0/0/0", out_valid, out_pdest, out_value);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    set_in(1, 1, 0, 6'h15, 0, 5'd3);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_T0: valid=%b, required 0", out_valid); end
    cyc();
    set_in(0, 0, 0, 6'h00, 0, 5'd0);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_T1: valid=%b, required 0", out_valid); end
    cyc();
    n_vec++;
    if (out_valid !== 1'b1 || out_pdest !== 6'h15 || out_rf !== 1'b1 || out_fp !== 1'b0
        || out_flag !== 1'b0 || out_value !== 5'd3) begin
      n_err++;
      $display("FAIL single_T2: valid=%b pdest=%0h rf=%b fp=%b rob=(%b,%0d), required 1 15 1 0 (0,3)",
               out_valid, out_pdest, out_rf, out_fp, out_flag, out_value);
    end
    cyc();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_T3: valid=%b, required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [PDEST_W-1:0] exp_pd [3];
    logic               exp_rf [3];
    logic               exp_fp [3];
    exp_pd[0] = 6'd1; exp_rf[0] = 1'b1; exp_fp[0] = 1'b0;
    exp_pd[1] = 6'd2; exp_rf[1] = 1'b0; exp_fp[1] = 1'b1;
    exp_pd[2] = 6'd3; exp_rf[2] = 1'b0; exp_fp[2] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (t < 3) set_in(1, exp_rf[t], exp_fp[t], exp_pd[t], 0, 5'(t + 1));
      else       set_in(0, 0, 0, 6'h00, 0, 5'd0);
      if (t >= 2 && t < 5) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pdest !== exp_pd[t-2] || out_rf !== exp_rf[t-2] || out_fp !== exp_fp[t-2]) begin
          n_err++;
          $display("FAIL b2b_T%0d: valid=%b pdest=%0d rf=%b fp=%b, required 1 %0d %b %b",
                   t, out_valid, out_pdest, out_rf, out_fp, exp_pd[t-2], exp_rf[t-2], exp_fp[t-2]);
        end
      end else if (t == 5) begin
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_T5: valid=%b, required 0", out_valid); end
      end
      cyc();
    end
  endtask

  // Entry enters at T0, redirect applied at T1 while the entry sits in stage 0.
  task automatic test_redirect_case(input string name, input logic ef, input logic [ROB_W-1:0] ev,
                                    input logic rf_, input logic [ROB_W-1:0] rv, input logic lvl,
                                    input logic exp_v);
    set_in(1, 1, 0, 6'h2A, ef, ev);
    cyc();
    set_in(0, 0, 0, 6'h00, 0, 5'd0);
    set_rd(1, rf_, rv, lvl);
    cyc();
    set_rd(0, 0, 5'd0, 0);
    n_vec++;
    if (out_valid !== exp_v || (exp_v && (out_pdest !== 6'h2A || out_flag !== ef || out_value !== ev))) begin
      n_err++;
      $display("FAIL redir_%s: valid=%b pdest=%0h rob=(%b,%0d), required valid=%b", name,
               out_valid, out_pdest, out_flag, out_value, exp_v);
    end
    cyc();
  endtask

  task automatic test_redirect_timing();
    // Redirect coincident with the input drops it before stage 0.
    set_in(1, 1, 0, 6'h11, 0, 5'd9);
    set_rd(1, 0, 5'd5, 0);
    cyc();
    set_in(0, 0, 0, 6'h00, 0, 5'd0);
    set_rd(0, 0, 5'd0, 0);
    cyc();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_same_cycle: valid=%b, required 0", out_valid); end
    cyc();
    // Redirect in the output cycle masks the wakeup combinationally.
    set_in(1, 1, 0, 6'h12, 0, 5'd9);
    cyc();
    set_in(0, 0, 0, 6'h00, 0, 5'd0);
    cyc();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL redir_out_pre: valid=%b, required 1", out_valid); end
    set_rd(1, 0, 5'd5, 0);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_pdest !== 6'h12) begin
      n_err++;
      $display("FAIL redir_out_mask: valid=%b pdest=%0h, required 0 12", out_valid, out_pdest);
    end
    set_rd(0, 0, 5'd0, 0);
    cyc();
  endtask

  task automatic test_async_reset();
    set_in(1, 1, 0, 6'h21, 0, 5'd1);
    cyc();
    set_in(1, 1, 0, 6'h22, 0, 5'd2);
    cyc();
    set_in(0, 0, 0, 6'h00, 0, 5'd0);
    n_vec++;
    if (out_valid !== 1'b1 || out_pdest !== 6'h21) begin
      n_err++;
      $display("FAIL rst_pre: valid=%b pdest=%0h, required 1 21", out_valid, out_pdest);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_pdest !== '0) begin
      n_err++;
      $display("FAIL rst_async: valid=%b pdest=%0h, required 0 0", out_valid, out_pdest);
    end
    cyc();
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cyc();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_after_%0d: valid=%b, required 0", t, out_valid); end
    end
`ifdef WAKEUP_DELAY_PERF_EN
    n_vec++;
    if (perf_flush !== 16'd0 || perf_wakeup !== 16'd0) begin
      n_err++;
      $display("FAIL rst_perf: flush=%0d wakeup=%0d, required 0 0", perf_flush, perf_wakeup);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 6'h00, 0, 5'd0);
    set_rd(0, 0, 5'd0, 0);
    #12;
    test_reset();
    test_single();
    test_back_to_back();
    test_redirect_case("older_kills",   0, 5'd10, 0, 5'd8,  0, 1'b0);
    test_redirect_case("younger_keeps", 0, 5'd10, 0, 5'd12, 0, 1'b1);
    test_redirect_case("equal_lvl1",    1, 5'd4,  1, 5'd4,  1, 1'b0);
    test_redirect_case("equal_lvl0",    1, 5'd4,  1, 5'd4,  0, 1'b1);
    test_redirect_case("wrap_kills",    1, 5'd2,  0, 5'd30, 0, 1'b0);
    test_redirect_case("flagdiff_eq",   1, 5'd7,  0, 5'd7,  0, 1'b0);
    test_redirect_timing();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
